// File: rtl/neo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : neo_pkg
// Purpose  : Shared types and default timing for the NeoPixel strand decoder.
// Revision : 1.0 - initial release
// ============================================================================
package neo_pkg;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        IDLE = 2'd1,
        HIGH = 2'd2,
        LOW  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        GREEN = 2'd0,
        RED   = 2'd1,
        BLUE  = 2'd2
    } color_t;

    localparam int c_NUM_PIXELS = 5;
    localparam int c_T_MIN_HIGH = 8;
    localparam int c_T_THRESH   = 27;
    localparam int c_T_MAX_HIGH = 50;
    localparam int c_T_LATCH    = 2500;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } grb_t;

endpackage
`default_nettype wire

// File: rtl/neo_bit_decoder.sv
`default_nettype none
// ============================================================================
// Module   : neo_bit_decoder
// Purpose  : Samples the strand line, times high/low phases, emits bits/latch.
// Revision : 1.0 - initial release
// ============================================================================
module neo_bit_decoder
    import neo_pkg::*;
#(
    parameter int T_MIN_HIGH = c_T_MIN_HIGH,
    parameter int T_THRESH   = c_T_THRESH,
    parameter int T_MAX_HIGH = c_T_MAX_HIGH,
    parameter int T_LATCH    = c_T_LATCH
) (
    input  logic clock,
    input  logic reset,
    input  logic neo_data,
    output logic bit_valid,
    output logic bit_value,
    output logic pulse_err,
    output logic latch
);

    localparam int c_HW = $clog2(T_MAX_HIGH + 2);
    localparam int c_LW = $clog2(T_LATCH + 1);
    localparam logic [c_HW-1:0] c_MIN    = c_HW'(T_MIN_HIGH);
    localparam logic [c_HW-1:0] c_THRESH = c_HW'(T_THRESH);
    localparam logic [c_HW-1:0] c_MAX    = c_HW'(T_MAX_HIGH);
    localparam logic [c_HW-1:0] c_SAT    = c_HW'(T_MAX_HIGH + 1);
    localparam logic [c_LW-1:0] c_LATCH  = c_LW'(T_LATCH);

    state_t          r_state, w_state_nxt;
    logic            r_data, r_data_d;
    logic [c_HW-1:0] r_high_cnt, w_high_nxt;
    logic [c_LW-1:0] r_low_cnt, w_low_nxt;
    logic            r_bit_valid, r_bit_value, r_pulse_err;
    logic            w_bit_valid, w_bit_value, w_pulse_err, w_latch;
    logic            w_rise, w_fall, w_in_range;

    assign w_rise     = r_data & ~r_data_d;
    assign w_fall     = ~r_data & r_data_d;
    assign w_in_range = (r_high_cnt >= c_MIN) && (r_high_cnt <= c_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= SYNC;
            r_data      <= 1'b0;
            r_data_d    <= 1'b0;
            r_high_cnt  <= '0;
            r_low_cnt   <= '0;
            r_bit_valid <= 1'b0;
            r_bit_value <= 1'b0;
            r_pulse_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_data      <= neo_data;
            r_data_d    <= r_data;
            r_high_cnt  <= w_high_nxt;
            r_low_cnt   <= w_low_nxt;
            r_bit_valid <= w_bit_valid;
            r_bit_value <= w_bit_value;
            r_pulse_err <= w_pulse_err;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_high_nxt  = r_high_cnt;
        w_low_nxt   = r_low_cnt;
        w_bit_valid = 1'b0;
        w_bit_value = 1'b0;
        w_pulse_err = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            SYNC: begin
                if (r_data) begin
                    w_low_nxt = '0;
                end else if (r_low_cnt == c_LATCH) begin
                    w_state_nxt = IDLE;
                    w_low_nxt   = '0;
                end else begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_high_nxt  = c_HW'(1);
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_bit_valid = w_in_range;
                    w_bit_value = w_in_range && (r_high_cnt >= c_THRESH);
                    w_pulse_err = !w_in_range;
                    w_state_nxt = LOW;
                    w_low_nxt   = c_LW'(1);
                end else if (r_high_cnt != c_SAT) begin
                    w_high_nxt = r_high_cnt + 1'b1;
                end
            end
            LOW: begin
                // A rise coinciding with the latch count both ends this frame and starts the next.
                if (r_low_cnt == c_LATCH) begin
                    w_latch     = 1'b1;
                    w_low_nxt   = '0;
                    w_state_nxt = w_rise ? HIGH : IDLE;
                    w_high_nxt  = c_HW'(1);
                end else if (w_rise) begin
                    w_state_nxt = HIGH;
                    w_high_nxt  = c_HW'(1);
                end else begin
                    w_low_nxt = r_low_cnt + 1'b1;
                end
            end
            default: w_state_nxt = SYNC;
        endcase
    end

    assign bit_valid = r_bit_valid;
    assign bit_value = r_bit_value;
    assign pulse_err = r_pulse_err;
    assign latch     = w_latch;

endmodule
`default_nettype wire

// File: rtl/neo_pixel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : neo_pixel_decoder
// Purpose  : Assembles decoded strand bits into GRB pixels and a readable frame.
// Revision : 1.0 - initial release
// ============================================================================
module neo_pixel_decoder
    import neo_pkg::*;
#(
    parameter int NUM_PIXELS = c_NUM_PIXELS,
    parameter int T_MIN_HIGH = c_T_MIN_HIGH,
    parameter int T_THRESH   = c_T_THRESH,
    parameter int T_MAX_HIGH = c_T_MAX_HIGH,
    parameter int T_LATCH    = c_T_LATCH
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        neo_data,
    input  logic [2:0]  pixel_index,
    input  logic [1:0]  color_index,
    output logic [7:0]  color_level,
    output logic        pixel_valid,
    output logic [2:0]  pixel_num,
    output logic [23:0] pixel_grb,
    output logic        frame_done,
    output logic        frame_ok,
    output logic        pulse_err,
    output logic        overflow_err
);

    localparam logic [3:0] c_NPIX     = 4'(NUM_PIXELS);
    localparam logic [4:0] c_LAST_BIT = 5'd23;

    logic        w_bit_valid, w_bit_value, w_pulse_err, w_latch;
    logic [23:0] r_shift;
    logic [4:0]  r_bit_cnt;
    logic [3:0]  r_pix_cnt;
    logic        r_err, r_any;
    logic        r_pixel_valid, r_frame_done, r_frame_ok;
    logic [2:0]  r_pixel_num;
    logic [23:0] r_pixel_grb;
    grb_t        r_mem [NUM_PIXELS];
    logic        w_full, w_overflow, w_store, w_word_done;
    logic [23:0] w_word;
    grb_t        w_sel;
    logic [7:0]  w_level;

    neo_bit_decoder #(
        .T_MIN_HIGH (T_MIN_HIGH),
        .T_THRESH   (T_THRESH),
        .T_MAX_HIGH (T_MAX_HIGH),
        .T_LATCH    (T_LATCH)
    ) u_bit_decoder (
        .clock      (clock),
        .reset      (reset),
        .neo_data   (neo_data),
        .bit_valid  (w_bit_valid),
        .bit_value  (w_bit_value),
        .pulse_err  (w_pulse_err),
        .latch      (w_latch)
    );

    assign w_full      = (r_pix_cnt == c_NPIX);
    assign w_overflow  = w_bit_valid && w_full;
    assign w_store     = w_bit_valid && !w_full;
    assign w_word      = {r_shift[22:0], w_bit_value};
    assign w_word_done = w_store && (r_bit_cnt == c_LAST_BIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_pix_cnt     <= '0;
            r_err         <= 1'b0;
            r_any         <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_pixel_num   <= '0;
            r_pixel_grb   <= '0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_ok    <= 1'b0;
            if (w_store) begin
                r_any <= 1'b1;
                if (w_word_done) begin
                    r_pixel_valid <= 1'b1;
                    r_pixel_num   <= r_pix_cnt[2:0];
                    r_pixel_grb   <= w_word;
                    r_pix_cnt     <= r_pix_cnt + 4'd1;
                    r_bit_cnt     <= '0;
                    r_shift       <= '0;
                end else begin
                    r_shift   <= w_word;
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            if (w_overflow) begin
                r_any <= 1'b1;
                r_err <= 1'b1;
            end
            if (w_pulse_err) begin
                r_err <= 1'b1;
            end
            // Latch never coincides with a bit or pulse error, so clearing here is safe.
            if (w_latch) begin
                r_frame_done <= r_any;
                r_frame_ok   <= r_any && w_full && (r_bit_cnt == 5'd0) && !r_err;
                r_shift      <= '0;
                r_bit_cnt    <= '0;
                r_pix_cnt    <= '0;
                r_err        <= 1'b0;
                r_any        <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_PIXELS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_word_done) begin
            r_mem[r_pix_cnt[2:0]] <= grb_t'(w_word);
        end
    end

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            if (pixel_index == 3'(i)) begin
                w_sel = r_mem[i];
            end
        end
        w_level = 8'd0;
        case (color_t'(color_index))
            GREEN:   w_level = w_sel.g;
            RED:     w_level = w_sel.r;
            BLUE:    w_level = w_sel.b;
            default: w_level = 8'd0;
        endcase
    end

    assign color_level  = w_level;
    assign pixel_valid  = r_pixel_valid;
    assign pixel_num    = r_pixel_num;
    assign pixel_grb    = r_pixel_grb;
    assign frame_done   = r_frame_done;
    assign frame_ok     = r_frame_ok;
    assign pulse_err    = w_pulse_err;
    assign overflow_err = w_overflow;

endmodule
`default_nettype wire

// File: tb/tb_neo_pixel_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_neo_pixel_decoder
// Purpose  : Directed self-checking bench for the NeoPixel strand decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_neo_pixel_decoder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        neo_data = 1'b0;
    logic [2:0]  pixel_index = 3'd0;
    logic [1:0]  color_index = 2'd0;
    logic [7:0]  color_level;
    logic        pixel_valid;
    logic [2:0]  pixel_num;
    logic [23:0] pixel_grb;
    logic        frame_done, frame_ok, pulse_err, overflow_err;

    int total = 0;
    int bad   = 0;

    logic [2:0]  pv_num [$];
    logic [23:0] pv_grb [$];
    int          fd_cnt = 0;
    logic        fd_ok  = 1'b0;
    int          pe_cnt = 0;
    int          ov_cnt = 0;

    neo_pixel_decoder dut (
        .clock        (clock),
        .reset        (reset),
        .neo_data     (neo_data),
        .pixel_index  (pixel_index),
        .color_index  (color_index),
        .color_level  (color_level),
        .pixel_valid  (pixel_valid),
        .pixel_num    (pixel_num),
        .pixel_grb    (pixel_grb),
        .frame_done   (frame_done),
        .frame_ok     (frame_ok),
        .pulse_err    (pulse_err),
        .overflow_err (overflow_err)
    );

    always #5 clock = ~clock;

    // Event log of output pulses, sampled 1 ns after each rising edge.
    always @(posedge clock) begin
        #1;
        if (pixel_valid) begin
            pv_num.push_back(pixel_num);
            pv_grb.push_back(pixel_grb);
        end
        if (frame_done) begin
            fd_cnt++;
            fd_ok = frame_ok;
        end
        if (pulse_err)    pe_cnt++;
        if (overflow_err) ov_cnt++;
    end

    task automatic clear_log();
        pv_num.delete();
        pv_grb.delete();
        fd_cnt = 0;
        fd_ok  = 1'b0;
        pe_cnt = 0;
        ov_cnt = 0;
    endtask

    task automatic send_pulse(input int h, input int l);
        neo_data = 1'b1;
        repeat (h) @(negedge clock);
        neo_data = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic send_bit(input logic b);
        if (b) send_pulse(35, 28);
        else   send_pulse(18, 45);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic idle(input int n);
        neo_data = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic rd(input logic [2:0] p, input logic [1:0] c, output logic [7:0] v);
        pixel_index = p;
        color_index = c;
        #1;
        v = color_level;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (pixel_valid !== 1'b0) begin bad++; $display("FAIL reset_pixel_valid got=%b want=0", pixel_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
        total++; if (frame_ok !== 1'b0) begin bad++; $display("FAIL reset_frame_ok got=%b want=0", frame_ok); end
        total++; if (pulse_err !== 1'b0) begin bad++; $display("FAIL reset_pulse_err got=%b want=0", pulse_err); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_overflow_err got=%b want=0", overflow_err); end
        total++; if (pixel_num !== 3'd0) begin bad++; $display("FAIL reset_pixel_num got=%0d want=0", pixel_num); end
        total++; if (pixel_grb !== 24'd0) begin bad++; $display("FAIL reset_pixel_grb got=%h want=0", pixel_grb); end
        rd(3'd2, 2'd0, v);
        total++; if (v !== 8'd0) begin bad++; $display("FAIL reset_color_level got=%h want=00", v); end
        @(negedge clock);
        reset = 1'b0;
        idle(2600);
        clear_log();
    endtask

    task automatic test_frame();
        logic [23:0] exp_w [5];
        logic [7:0]  v;
        exp_w[0] = 24'h00FF00; exp_w[1] = 24'h123456; exp_w[2] = 24'hABCDEF;
        exp_w[3] = 24'h000001; exp_w[4] = 24'h800000;
        clear_log();
        for (int p = 0; p < 5; p++) send_word(exp_w[p]);
        idle(2600);
        total++; if (pv_grb.size() !== 5) begin bad++; $display("FAIL frame_pixel_count got=%0d want=5", pv_grb.size()); end
        for (int p = 0; p < 5 && p < pv_grb.size(); p++) begin
            total++; if (pv_num[p] !== 3'(p)) begin bad++; $display("FAIL frame_pixel_num[%0d] got=%0d want=%0d", p, pv_num[p], p); end
            total++; if (pv_grb[p] !== exp_w[p]) begin bad++; $display("FAIL frame_pixel_grb[%0d] got=%h want=%h", p, pv_grb[p], exp_w[p]); end
        end
        total++; if (fd_cnt !== 1) begin bad++; $display("FAIL frame_done_count got=%0d want=1", fd_cnt); end
        total++; if (fd_ok !== 1'b1) begin bad++; $display("FAIL frame_ok got=%b want=1", fd_ok); end
        total++; if (pe_cnt !== 0 || ov_cnt !== 0) begin bad++; $display("FAIL frame_errors got=%0d/%0d want=0/0", pe_cnt, ov_cnt); end
        rd(3'd2, 2'd0, v);
        total++; if (v !== 8'hAB) begin bad++; $display("FAIL read_p2_green got=%h want=ab", v); end
        rd(3'd2, 2'd1, v);
        total++; if (v !== 8'hCD) begin bad++; $display("FAIL read_p2_red got=%h want=cd", v); end
        rd(3'd2, 2'd2, v);
        total++; if (v !== 8'hEF) begin bad++; $display("FAIL read_p2_blue got=%h want=ef", v); end
        rd(3'd2, 2'd3, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL read_p2_reserved got=%h want=00", v); end
        rd(3'd4, 2'd0, v);
        total++; if (v !== 8'h80) begin bad++; $display("FAIL read_p4_green got=%h want=80", v); end
        rd(3'd5, 2'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL read_p5_out_of_range got=%h want=00", v); end
    endtask

    task automatic test_loopback();
        logic [7:0] v;
        clear_log();
        send_word(24'h000000);
        send_word(24'h007F00);
        send_word(24'h000000);
        send_word(24'h000000);
        send_word(24'h000000);
        idle(2600);
        rd(3'd1, 2'd1, v);
        total++; if (v !== 8'h7F) begin bad++; $display("FAIL loop_p1_red got=%h want=7f", v); end
        rd(3'd1, 2'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL loop_p1_green got=%h want=00", v); end
        total++; if (fd_cnt !== 1 || fd_ok !== 1'b1) begin bad++; $display("FAIL loop_frame_ok got=%0d/%b want=1/1", fd_cnt, fd_ok); end
    endtask

    task automatic test_pulse_err();
        logic [23:0] w;
        logic [7:0]  v;
        w = 24'h5A5A5A;
        clear_log();
        for (int i = 23; i >= 12; i--) send_bit(w[i]);
        send_pulse(4, 45);
        for (int i = 11; i >= 0; i--) send_bit(w[i]);
        for (int p = 1; p < 5; p++) send_word(w);
        idle(2600);
        total++; if (pe_cnt !== 1) begin bad++; $display("FAIL perr_count got=%0d want=1", pe_cnt); end
        total++; if (pv_grb.size() !== 5) begin bad++; $display("FAIL perr_pixel_count got=%0d want=5", pv_grb.size()); end
        total++; if (pv_grb.size() > 0 && pv_grb[0] !== w) begin bad++; $display("FAIL perr_word0 got=%h want=%h", pv_grb[0], w); end
        total++; if (fd_cnt !== 1 || fd_ok !== 1'b0) begin bad++; $display("FAIL perr_frame got=%0d/%b want=1/0", fd_cnt, fd_ok); end
        rd(3'd0, 2'd0, v);
        total++; if (v !== 8'h5A) begin bad++; $display("FAIL perr_read_p0 got=%h want=5a", v); end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        clear_log();
        for (int p = 0; p < 4; p++) send_word(24'h010203);
        send_word(24'h445566);
        send_word(24'hFFFFFF);
        idle(2600);
        total++; if (ov_cnt !== 24) begin bad++; $display("FAIL ovf_count got=%0d want=24", ov_cnt); end
        total++; if (pv_grb.size() !== 5) begin bad++; $display("FAIL ovf_pixel_count got=%0d want=5", pv_grb.size()); end
        total++; if (fd_cnt !== 1 || fd_ok !== 1'b0) begin bad++; $display("FAIL ovf_frame got=%0d/%b want=1/0", fd_cnt, fd_ok); end
        rd(3'd4, 2'd0, v);
        total++; if (v !== 8'h44) begin bad++; $display("FAIL ovf_read_p4 got=%h want=44", v); end
    endtask

    task automatic test_gap();
        logic [23:0] w0;
        logic [23:0] w4;
        w0 = 24'hC3A5F0;
        w4 = 24'h00000F;
        clear_log();
        for (int i = 23; i >= 12; i--) send_bit(w0[i]);
        if (w0[11]) send_pulse(35, 2499);
        else        send_pulse(18, 2499);
        for (int i = 10; i >= 0; i--) send_bit(w0[i]);
        send_word(24'h111111);
        send_word(24'h123456);
        send_word(24'h333333);
        for (int i = 23; i >= 1; i--) send_bit(w4[i]);
        total++; if (fd_cnt !== 0) begin bad++; $display("FAIL gap_2499_frame_done got=%0d want=0", fd_cnt); end
        neo_data = 1'b1;
        repeat (35) @(negedge clock);
        neo_data = 1'b0;
        for (int k = 0; k <= 2501; k++) begin
            @(posedge clock);
            #1;
            if (k == 2500) begin
                total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL gap_done_early got=%b want=0", frame_done); end
            end
            if (k == 2501) begin
                total++; if (frame_done !== 1'b1) begin bad++; $display("FAIL gap_done_at_2501 got=%b want=1", frame_done); end
                total++; if (frame_ok !== 1'b1) begin bad++; $display("FAIL gap_frame_ok got=%b want=1", frame_ok); end
            end
        end
        @(negedge clock);
        idle(50);
        total++; if (pv_grb.size() !== 5) begin bad++; $display("FAIL gap_pixel_count got=%0d want=5", pv_grb.size()); end
        total++; if (pv_grb.size() > 0 && pv_grb[0] !== w0) begin bad++; $display("FAIL gap_word0 got=%h want=%h", pv_grb[0], w0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        clear_log();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        reset = 1'b1;
        neo_data = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (pixel_valid !== 1'b0 || frame_done !== 1'b0 || pulse_err !== 1'b0 || overflow_err !== 1'b0)
            begin bad++; $display("FAIL rst_mid_pulses got=%b%b%b%b want=0000", pixel_valid, frame_done, pulse_err, overflow_err); end
        total++; if (pixel_grb !== 24'd0 || pixel_num !== 3'd0) begin bad++; $display("FAIL rst_mid_pixel got=%h/%0d want=0/0", pixel_grb, pixel_num); end
        rd(3'd2, 2'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL rst_mid_storage got=%h want=00", v); end
        reset = 1'b0;
        clear_log();
        for (int p = 0; p < 5; p++) send_word(24'h9A9A9A);
        idle(2600);
        total++; if (pv_grb.size() !== 0 || fd_cnt !== 0) begin bad++; $display("FAIL sync_ignored got=%0d/%0d want=0/0", pv_grb.size(), fd_cnt); end
        rd(3'd0, 2'd0, v);
        total++; if (v !== 8'h00) begin bad++; $display("FAIL sync_storage got=%h want=00", v); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_frame();
        test_loopback();
        test_pulse_err();
        test_overflow();
        test_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/neo_pixel_decoder.md
# neo_pixel_decoder

Receive-side counterpart of the NeoPixel strand controller. It samples the single-wire `neo_data` stream and measures each high pulse to recover bits. It assembles the bits MSB-first into 24-bit GRB pixel words, detects the 50 µs latch gap, and stores one frame of pixels in a readable register file. It sits on the strand wire in loopback benches and in checker hardware, so a transmitted frame can be read back through the same pixel/color addressing the loader uses.

## Interface
- `NUM_PIXELS`, 5, pixels per frame (≤ 8).
- `T_MIN_HIGH`, 8, shortest legal high pulse, in clocks.
- `T_THRESH`, 27, high pulses of this many clocks or more decode as 1; shorter pulses decode as 0.
- `T_MAX_HIGH`, 50, longest legal high pulse, in clocks.
- `T_LATCH`, 2500, low clocks that end a frame (50 µs at 50 MHz).
- `clock` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `neo_data` in 1 — strand serial line, same clock domain.
- `pixel_index` in 3 — read address, pixel.
- `color_index` in 2 — read address, color: 0 = green, 1 = red, 2 = blue, 3 = reserved.
- `color_level` out 8 — combinational read of the stored level; returns 0 for a reserved color or when `pixel_index` ≥ NUM_PIXELS.
- `pixel_valid` out 1 — one-cycle pulse when a pixel word completes.
- `pixel_num` out 3 — index of the completed pixel; valid with `pixel_valid`.
- `pixel_grb` out 24 — completed word {G,R,B}; valid with `pixel_valid`.
- `frame_done` out 1 — one-cycle pulse at the latch gap ending a frame that contained at least one bit.
- `frame_ok` out 1 — valid with `frame_done`: exactly NUM_PIXELS×24 bits and no error in the frame.
- `pulse_err` out 1 — one-cycle pulse when a high pulse is outside [T_MIN_HIGH, T_MAX_HIGH].
- `overflow_err` out 1 — one-cycle pulse for each bit received beyond NUM_PIXELS×24 in a frame.

## Operation
- `neo_data` is registered once; edge detection uses the registered sample and its previous value.
- States:
  - SYNC (after reset) — counts consecutive low samples; any high clears the count; on reaching T_LATCH → IDLE. No `frame_done` is issued on this transition.
  - IDLE — at a frame boundary; a rising edge → HIGH with high_count = 1.
  - HIGH — increments high_count, saturating at T_MAX_HIGH+1. On the falling edge the pulse is classified, then → LOW with low_count = 1.
  - LOW — increments low_count. A rising edge → HIGH. When low_count reaches T_LATCH: end of frame, → IDLE.
- Pulse classification on a falling edge:
  - In range: shift in 1 if high_count ≥ T_THRESH, else 0.
  - Out of range: pulse `pulse_err`; no bit is shifted; the frame error flag is set.
- Pixel assembly:
  - After the 24th bit of a word: pulse `pixel_valid`, write the word to storage at `pixel_num`, increment the pixel counter, clear the bit counter.
  - Once the pixel counter reaches NUM_PIXELS, each further bit pulses `overflow_err`, is discarded, and sets the frame error flag.
- End of frame, when the bit total > 0:
  - Pulse `frame_done`.
  - `frame_ok` = (pixel counter == NUM_PIXELS) && (bit counter == 0) && !error.
  - A partial word is discarded and is not written.
  - Pixel counter, bit counter, shift register and error flag are cleared.
- A latch gap with zero bits returns to IDLE silently.
- Storage holds the last written value per pixel. It is not cleared at a frame boundary; only `reset` clears it.
- Reset at any cycle: all outputs 0, storage 0, counters 0, state SYNC.

## Timing
- Reset values: `color_level` = 0 (storage is all zero); `pixel_valid`, `frame_done`, `frame_ok`, `pulse_err` and `overflow_err` are 0; `pixel_num` and `pixel_grb` are 0.
- Falling edge on `neo_data` at cycle n → bit shifted, with any `pulse_err`/`overflow_err`, at n+1. For the 24th bit, `pixel_valid`, `pixel_num` and `pixel_grb` are registered at n+2.
- Storage write takes effect with `pixel_valid`. A read of that pixel returns the new value from the following cycle.
- Line low from cycle n with no further rise → `frame_done` at n+T_LATCH+1.
- A rise at any low_count < T_LATCH continues the frame. T_LATCH−1 low clocks is not a latch.
- `pulse_err` is evaluated at the falling edge only; a line stuck high does not latch or error until it falls.

## Structure
- Package `neo_pkg`:
  - state enum (SYNC, IDLE, HIGH, LOW);
  - color index enum (GREEN = 0, RED = 1, BLUE = 2);
  - default timing constants;
  - `grb_t` struct {g,r,b}.
- Sub-module `neo_bit_decoder`:
  - contains the input register, edge detect, high/low counters and the state machine;
  - emits `bit_valid`, `bit_value`, `pulse_err` and `latch`;
  - the top level does word/pixel assembly and storage.

## Test plan
- Reset, line low 2500 cycles, then 5 pixels 0x00FF00, 0x123456, 0xABCDEF, 0x000001, 0x800000 (1 = 35 high/28 low, 0 = 18 high/45 low), then low 2500 → 5 `pixel_valid` pulses with `pixel_num` 0..4 and matching `pixel_grb`, `frame_done` with `frame_ok` = 1; reading pixel 2 gives green 0xAB, red 0xCD, blue 0xEF; reading color 3 gives 0.
- Drive the strand controller's `neo_data` directly after loading pixel 1 red = 0x7F → readback pixel 1 color 1 = 0x7F; `frame_ok` = 1.
- A 4-clock high pulse mid-word → `pulse_err` pulse, bit skipped, `frame_ok` = 0 at the latch.
- 6 pixels sent → 24 `overflow_err` pulses, only 5 `pixel_valid`, `frame_ok` = 0.
- Low gap of 2499 between bits → no `frame_done`, word continues; a gap of 2500 → `frame_done` exactly at fall+2501.
- Assert `reset` mid-word → all outputs 0, storage 0. A frame sent before 2500 low cycles elapse is ignored (SYNC).
